count_seq: RTL and testbench



---
 rtl/count_seq_pkg.sv | 10 +
 rtl/count_seq_presc.sv | 35 +++
 rtl/count_seq.sv | 139 +++++++++++++
 tb/tb_count_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count_seq sequencing controller.
package count_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam int CNT_W_DEF   = 8;
    localparam int PRESC_W_DEF = 4;
    localparam int WRAPS_W     = 8;

endpackage

// File: rtl/count_seq_presc.sv
// Clock prescaler: emits a one-cycle tick every presc_q+1 enabled cycles.
module count_seq_presc
    import count_seq_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc_q,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == presc_q);

    // clr wins over en; a disabled prescaler keeps its phase
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/count_seq.sv
// Sequencing controller for the event counter: start/stop/hold, prescaled
// counting to a terminal value, done pulse. Optional wraps output: COUNT_SEQ_WRAPS_EN.
module count_seq
    import count_seq_pkg::*;
#(
    parameter int WIDTH   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               reload,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
`ifdef COUNT_SEQ_WRAPS_EN
    output logic [WRAPS_W-1:0] wraps,
`endif
    output logic               done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               reload_q, reload_d;
    logic               done_q, done_d;
    logic               wrap_evt;
    logic               tick;
    logic               presc_clr, presc_en;

    // stop/start take priority, so they also suppress this cycle's tick
    assign presc_clr = stop || start;
    assign presc_en  = (state_q == RUN) && !hold && !stop && !start;

    count_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk     (clk),
        .reset   (reset),
        .clr     (presc_clr),
        .en      (presc_en),
        .presc_q (presc_q),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        presc_d  = presc_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        wrap_evt = 1'b0;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            limit_d  = limit;
            presc_d  = presc;
            reload_d = reload;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (hold) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        if (count_q == limit_q) begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d  = '0;
                                wrap_evt = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!hold)
                        state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            presc_q  <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = done_q;

`ifdef COUNT_SEQ_WRAPS_EN
    logic [WRAPS_W-1:0] wraps_q, wraps_d;

    always_comb begin
        wraps_d = wraps_q;
        if (stop || start)
            wraps_d = '0;
        else if (wrap_evt && (wraps_q != {WRAPS_W{1'b1}}))
            wraps_d = wraps_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wraps_q <= '0;
        else
            wraps_q <= wraps_d;
    end

    assign wraps = wraps_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_evt;
`endif

endmodule

// File: tb/tb_count_seq.sv
// Directed self-checking bench for count_seq; expected values hand-derived.
module tb_count_seq;

    logic       clk, reset, start, stop, hold, reload;
    logic [7:0] limit;
    logic [3:0] presc;
    logic [7:0] count;
    logic       busy, done;
`ifdef COUNT_SEQ_WRAPS_EN
    logic [7:0] wraps;
`endif

    int n_vec = 0;
    int n_err = 0;

    count_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .hold   (hold),
        .reload (reload),
        .limit  (limit),
        .presc  (presc),
        .count  (count),
        .busy   (busy),
`ifdef COUNT_SEQ_WRAPS_EN
        .wraps  (wraps),
`endif
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int c, input int b, input int d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic do_start(input int lim, input int pre, input bit rel);
        limit = 8'(lim); presc = 4'(pre); reload = rel; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; reload = 1'b0;
        limit = '0; presc = '0;
        #12;
        chk3("reset", 0, 0, 0);
        step();
        reset = 1'b0;
        step();
        chk3("idle", 0, 0, 0);

        // one-shot, presc=0, limit=3; inputs changed after start must be ignored
        do_start(3, 0, 1'b0);
        limit = 8'd0; presc = 4'd5; reload = 1'b1;
        chk3("os.e0", 0, 1, 0);
        step(); chk3("os.e1", 1, 1, 0);
        step(); chk3("os.e2", 2, 1, 0);
        step(); chk3("os.e3", 3, 1, 0);
        step(); chk3("os.e4", 3, 0, 1);
        step(); chk3("os.e5", 3, 0, 0);
        step(); chk3("os.e6", 3, 0, 0);

        // auto-reload, presc=2, limit=1: count 0,0,1,1,1,0,... done every 6
        do_start(1, 2, 1'b1);
        chk3("ar.e0", 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk3($sformatf("ar.e%0d", i), (i / 3) % 2, 1, (i % 6 == 0) ? 1 : 0);
        end

        // hold: presc=1, limit=9; count=2 after edge 4, prescaler at phase 1 after edge 5
        do_start(9, 1, 1'b0);
        step(); step(); step(); step();
        chk3("hd.e4", 2, 1, 0);
        step();
        chk3("hd.e5", 2, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3($sformatf("hd.h%0d", i), 2, 1, 0);
        end
        hold = 1'b0;
        step(); chk3("hd.rel", 2, 1, 0);
        step(); chk3("hd.res", 3, 1, 0);
        step(); chk3("hd.res2", 3, 1, 0);

        // stop and start in the same cycle at count=5: stop wins
        do_start(9, 0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk3("ss.pre", 5, 1, 0);
        stop = 1'b1; start = 1'b1; limit = 8'd2;
        step();
        stop = 1'b0; start = 1'b0;
        chk3("ss.e0", 0, 0, 0);
        step(); chk3("ss.e1", 0, 0, 0);

        // asynchronous reset between edges at count=7
        do_start(20, 0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk3("ar.pre", 7, 1, 0);
        #2 reset = 1'b1;
        #1 chk3("arst", 0, 0, 0);
        #2 reset = 1'b0;
        step(); chk3("arst.post", 0, 0, 0);

        // limit=0, presc=0, auto-reload: done every cycle after the first
        do_start(0, 0, 1'b1);
        chk3("l0.e0", 0, 1, 0);
        for (int i = 1; i <= 300; i++) begin
            step();
            chk3($sformatf("l0.e%0d", i), 0, 1, 1);
        end
`ifdef COUNT_SEQ_WRAPS_EN
        chk("l0.wraps", 32'(wraps), 32'd255);
`endif
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk3("l0.stop", 0, 0, 0);
`ifdef COUNT_SEQ_WRAPS_EN
        chk("l0.wraps_clr", 32'(wraps), 32'd0);
`endif
        step(); chk3("l0.idle", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
